// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: req/ack handshake to data memory with byte-lane alignment
// and load extension. Optional ack-wait watchdog enabled by LSU_TIMEOUT_EN.

module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic       we_i,
  input  logic [1:0] size_i,
  input  logic [1:0] off_i,
  input  logic [7:0] sb_i,
  input  logic [7:0] sh_i,
  input  logic [7:0] sw_i,
  output logic       be_o,
  output logic [7:0] byte_o
);
  localparam logic [1:0] LID = 2'(LANE);

  always_comb begin
    be_o   = 1'b1;
    byte_o = sw_i;
    if (we_i) begin
      case (size_i)
        2'b00: begin be_o = (off_i == LID);       byte_o = sb_i; end
        2'b01: begin be_o = (off_i[1] == LID[1]); byte_o = sh_i; end
        default: ;
      endcase
    end
  end
endmodule

module lsu_mem_ctrl #(
  parameter int ANCHO   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       funct3,
  input  logic [ANCHO-1:0] address,
  input  logic [ANCHO-1:0] data_out,
  output logic [ANCHO-1:0] Memoria,
  output logic             done,
  output logic             busy,
  output logic             flagError,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ANCHO-1:0] mem_addr,
  output logic [ANCHO-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [ANCHO-1:0] mem_rdata,
  input  logic             mem_ack
);
  localparam int NUM_LANES = ANCHO / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

  typedef struct packed {
    logic                 we;
    logic [2:0]           f3;
    logic [1:0]           off;
    logic [ANCHO-1:0]     addr;
    logic [ANCHO-1:0]     wdata;
    logic [NUM_LANES-1:0] be;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q, req_n;
  logic [ANCHO-1:0] mem_q;

  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_lane #(.LANE(g)) u_lane (
      .we_i   (req_we),
      .size_i (funct3[1:0]),
      .off_i  (address[1:0]),
      .sb_i   (data_out[7:0]),
      .sh_i   (data_out[8*(g%2) +: 8]),
      .sw_i   (data_out[8*g +: 8]),
      .be_o   (lane_be[g]),
      .byte_o (lane_wdata[g])
    );
  end

  logic legal, aligned, accept_ok;
  always_comb begin
    legal = req_we ? (funct3 inside {3'd0, 3'd1, 3'd2})
                   : (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (funct3[1:0])
      2'b01:   aligned = ~address[0];
      2'b10:   aligned = (address[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    accept_ok = legal && aligned;
  end

  always_comb begin
    req_n.we    = req_we;
    req_n.f3    = funct3;
    req_n.off   = address[1:0];
    req_n.addr  = {address[ANCHO-1:2], 2'b00};
    req_n.wdata = lane_wdata;
    req_n.be    = lane_be;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo;
  assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               cnt_q <= '0;
    else if (state_q == S_IDLE)             cnt_q <= '0;
    else if (state_q == S_REQ && !mem_ack)  cnt_q <= cnt_q + 1'b1;
  end
`else
  logic             tmo;
  logic [31:0]      unused_timeout;
  assign tmo            = 1'b0;
  assign unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = accept_ok ? S_REQ : S_ERR;
      S_REQ: begin
        if (mem_ack)  state_d = S_RESP;
        else if (tmo) state_d = S_ERR;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Extraction uses the offset captured at accept, not the live address.
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic [ANCHO-1:0] ld_ext;
  always_comb begin
    ld_b = mem_rdata[{req_q.off, 3'b000} +: 8];
    ld_h = mem_rdata[{req_q.off[1], 4'b0000} +: 16];
    case (req_q.f3)
      3'd0:    ld_ext = {{(ANCHO-8){ld_b[7]}}, ld_b};
      3'd4:    ld_ext = {{(ANCHO-8){1'b0}}, ld_b};
      3'd1:    ld_ext = {{(ANCHO-16){ld_h[15]}}, ld_h};
      3'd5:    ld_ext = {{(ANCHO-16){1'b0}}, ld_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
      mem_q <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid && accept_ok) req_q <= req_n;
      if (state_q == S_REQ && mem_ack && !req_q.we)    mem_q <= ld_ext;
    end
  end

  assign Memoria   = mem_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP) || (state_q == S_ERR);
  assign flagError = (state_q == S_ERR);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, hand-written reset/timeout
// sequences, then random accesses checked against a behavioural model.

module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] address, data_out, mem_rdata;
  logic [31:0] Memoria, mem_addr, mem_wdata;
  logic        done, busy, flagError, mem_req, mem_we;
  logic [3:0]  mem_be;

  lsu_mem_ctrl #(.ANCHO(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .address(address), .data_out(data_out), .Memoria(Memoria), .done(done),
    .busy(busy), .flagError(flagError), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_mem = 32'h0;

  typedef struct {
    bit          err;
    bit [3:0]    be;
    bit [31:0]   wdata;
    bit [31:0]   mem;
  } exp_t;

  typedef struct {
    bit          we;
    bit [2:0]    f3;
    bit [31:0]   addr;
    bit [31:0]   data;
    int          waits;
    bit [31:0]   rdata;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: derived from access size/offset arithmetic.
  function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                 input bit [31:0] d, input bit [31:0] r, input bit [31:0] prev);
    exp_t e;
    int   off  = int'(a % 4);
    int   size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    bit   legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    bit [31:0] w, bb, hh;
    e.err = !legal || (a % size != 0);
    e.be = 4'hF; e.wdata = 32'h0; e.mem = prev;
    if (e.err) return e;
    if (we) begin
      bb = d & 32'hFF; hh = d & 32'hFFFF;
      if (size == 1) begin e.be = 4'(1 << off); e.wdata = bb * 32'h01010101; end
      else if (size == 2) begin e.be = (off >= 2) ? 4'hC : 4'h3; e.wdata = hh * 32'h00010001; end
      else e.wdata = d;
    end else begin
      w = r >> (8 * off);
      if (size == 1) begin
        e.mem = w & 32'hFF;
        if (f3 == 0 && e.mem >= 128) e.mem = e.mem + 32'hFFFFFF00;
      end else if (size == 2) begin
        e.mem = w & 32'hFFFF;
        if (f3 == 1 && e.mem >= 32768) e.mem = e.mem + 32'hFFFF0000;
      end else e.mem = r;
    end
    return e;
  endfunction

  task automatic access(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d,
                        input int waits, input bit [31:0] r, input exp_t e, input string tag);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; address = a; data_out = d; mem_ack = 1'b0;
    @(negedge clk);
    if (e.err) begin
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".flagError"}, 32'(flagError), 32'd1);
      chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".Memoria"}, Memoria, e.mem);
      req_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    end else begin
      chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
      chk({tag, ".mem_addr"}, mem_addr, a & 32'hFFFFFFFC);
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
      chk({tag, ".mem_be"}, 32'(mem_be), 32'(e.be));
      if (we) chk({tag, ".mem_wdata"}, mem_wdata, e.wdata);
      address = ~a; data_out = ~d;
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        chk({tag, ".wait_req"}, {mem_req, done, mem_addr[31:2]}, {2'b10, a[31:2]});
      end
      mem_ack = 1'b1; mem_rdata = r;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".flagError"}, 32'(flagError), 32'd0);
      chk({tag, ".Memoria"}, Memoria, e.mem);
      req_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".idle"}, {30'b0, busy, done}, 32'd0);
    end
    exp_mem = e.mem;
  endtask

  vec_t vt[14];
  exp_t em;
  int   nreq;
  bit   seen;

  initial begin
    rst = 1'b0; req_valid = 0; req_we = 0; funct3 = 0; address = 0; data_out = 0;
    mem_rdata = 0; mem_ack = 0;

    vt[0]  = '{0, 3'd2, 32'h100, 32'h0,        0, 32'hDEADBEEF, '{0, 4'hF, 32'h0,        32'hDEADBEEF}};
    vt[1]  = '{0, 3'd0, 32'h103, 32'h0,        3, 32'h80AABBCC, '{0, 4'hF, 32'h0,        32'hFFFFFF80}};
    vt[2]  = '{0, 3'd4, 32'h103, 32'h0,        3, 32'h80AABBCC, '{0, 4'hF, 32'h0,        32'h00000080}};
    vt[3]  = '{1, 3'd1, 32'h202, 32'h1234ABCD, 1, 32'h0,        '{0, 4'hC, 32'hABCDABCD, 32'h00000080}};
    vt[4]  = '{0, 3'd2, 32'h101, 32'h0,        0, 32'h0,        '{1, 4'hF, 32'h0,        32'h00000080}};
    vt[5]  = '{1, 3'd3, 32'h40,  32'h11,       0, 32'h0,        '{1, 4'hF, 32'h0,        32'h00000080}};
    vt[6]  = '{1, 3'd0, 32'h41,  32'hAABBCC55, 0, 32'h0,        '{0, 4'h2, 32'h55555555, 32'h00000080}};
    vt[7]  = '{0, 3'd1, 32'h102, 32'h0,        2, 32'h80017FFF, '{0, 4'hF, 32'h0,        32'hFFFF8001}};
    vt[8]  = '{0, 3'd5, 32'h102, 32'h0,        0, 32'h80017FFF, '{0, 4'hF, 32'h0,        32'h00008001}};
    vt[9]  = '{0, 3'd1, 32'h101, 32'h0,        0, 32'h0,        '{1, 4'hF, 32'h0,        32'h00008001}};
    vt[10] = '{1, 3'd2, 32'h8,   32'hCAFEF00D, 0, 32'h0,        '{0, 4'hF, 32'hCAFEF00D, 32'h00008001}};
    vt[11] = '{0, 3'd6, 32'h0,   32'h0,        0, 32'h0,        '{1, 4'hF, 32'h0,        32'h00008001}};
    vt[12] = '{1, 3'd5, 32'h0,   32'h0,        0, 32'h0,        '{1, 4'hF, 32'h0,        32'h00008001}};
    vt[13] = '{0, 3'd0, 32'h100, 32'h0,        1, 32'h0000007F, '{0, 4'hF, 32'h0,        32'h0000007F}};

    #12;
    chk("reset.outs", {29'b0, done, busy, flagError}, 32'd0);
    chk("reset.bus", {mem_req, mem_we, 26'b0, mem_be}, 32'd0);
    chk("reset.addr_wdata", mem_addr | mem_wdata, 32'd0);
    chk("reset.Memoria", Memoria, 32'd0);
    @(negedge clk); rst = 1'b1;

    foreach (vt[i])
      access(vt[i].we, vt[i].f3, vt[i].addr, vt[i].data, vt[i].waits, vt[i].rdata,
             vt[i].e, $sformatf("vec%0d", i));

    // Reset while a store is outstanding: abandoned, no done pulse.
    @(negedge clk);
    req_valid = 1; req_we = 1; funct3 = 3'd2; address = 32'h10; data_out = 32'h12345678;
    @(negedge clk);
    chk("rstmid.req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid.req_now", {30'b0, mem_req, busy}, 32'd0);
    req_valid = 0;
    @(negedge clk);
    chk("rstmid.nodone", {30'b0, done, flagError}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.nodone2", 32'(done), 32'd0);
    exp_mem = 32'h0;
    access(0, 3'd2, 32'h20, 32'h0, 0, 32'h0BADF00D, model(0, 3'd2, 32'h20, 0, 32'h0BADF00D, exp_mem), "post_rst");

    // Memory never acks.
    @(negedge clk);
    req_valid = 1; req_we = 0; funct3 = 3'd2; address = 32'h30; mem_ack = 0;
    nreq = 0; seen = 0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (mem_req) nreq++;
    end
    chk("tmo.done_seen", 32'(seen), 32'd1);
    chk("tmo.req_cycles", nreq, 32'd4);
    chk("tmo.err", {30'b0, flagError, mem_req}, 32'b10);
    chk("tmo.Memoria", Memoria, exp_mem);
    req_valid = 0;
    @(negedge clk);
`else
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (mem_req && !done) nreq++;
    end
    chk("hang.req_cycles", nreq, 32'd120);
    #2 rst = 1'b0; req_valid = 0;
    @(negedge clk); rst = 1'b1;
    exp_mem = 32'h0;
`endif

    for (int n = 0; n < 150; n++) begin
      bit        we = 1'($urandom);
      bit [2:0]  f3 = 3'($urandom_range(0, 7));
      bit [31:0] a  = $urandom;
      bit [31:0] d  = $urandom;
      bit [31:0] r  = $urandom;
      if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      em = model(we, f3, a, d, r, exp_mem);
      access(we, f3, a, d, $urandom_range(0, 3), r, em, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller on the memory side of the register-file/ALU datapath.
- Accepts the ALU-computed `address`, store data `data_out`, access type (`funct3`) and direction (`req_we`).
- Runs a req/ack handshake to data memory, with byte lanes and write data aligned onto a word bus.
- Returns the sign/zero-extended load result on `Memoria`, which feeds writeback select 2. `busy` stalls the core while an access is outstanding.

Parameters:
- ANCHO, 32, data/address width; only 32 is supported.
- TIMEOUT, 255, ack-wait limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  access request; held high by the core until `done`
- req_we  in  1  1=store, 0=load
- funct3  in  3  RV32I width code: 0=B, 1=H, 2=W, 4=BU, 5=HU
- address  in  32  byte address from the ALU
- data_out  in  32  store data (rs2)
- Memoria  out  32  extended load result
- done  out  1  one-cycle completion pulse
- busy  out  1  high while not IDLE
- flagError  out  1  misaligned/illegal access; valid in the `done` cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, {address[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data; valid when `mem_ack`=1
- mem_ack  in  1  memory accepts/finishes the request

Behaviour:
- Reset (rst=0, async): state=IDLE; Memoria, mem_addr, mem_wdata = 0; done, busy, flagError, mem_req, mem_we, mem_be = 0.
- State IDLE, on req_valid=1 (sampled at clk):
  - Legal and aligned → REQ. All request fields are registered: addr, we, funct3, wdata, be.
  - Illegal or misaligned → ERR.
- Legality:
  - Loads: funct3 ∈ {0,1,2,4,5}. Stores: funct3 ∈ {0,1,2}.
  - Halfword needs address[0]=0. Word needs address[1:0]=0.
- State REQ: mem_req=1, with mem_we/mem_addr/mem_wdata/mem_be held stable.
  - mem_ack=1 → RESP; mem_rdata is latched that edge.
  - mem_ack=0 → stay in REQ.
- State RESP (one cycle): done=1, flagError=0 → IDLE.
  - Load: Memoria updated at entry to RESP.
  - Store: Memoria unchanged.
- State ERR (one cycle): done=1, flagError=1, mem_req=0 → IDLE. No memory access is issued; Memoria unchanged.
- Latency:
  - Request accepted at edge 0; mem_req is high from edge 0.
  - Ack in cycle k → done in cycle k+1.
  - Minimum load/store is 2 cycles (zero-wait ack).
- Store lanes: off=address[1:0].
  - SB: be=1<<off, wdata={4{data[7:0]}}.
  - SH: be=off[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - SW: be=4'b1111, wdata=data.
- Loads: mem_we=0, be=4'b1111. Extraction uses the registered offset:
  - LB/LBU: byte = rdata>>(8*off), sign- or zero-extended.
  - LH/LHU: half = rdata>>(16*off[1]), sign- or zero-extended.
  - LW: full word.
- busy: high in REQ, RESP and ERR.
- req_valid still high during `done`: ignored; IDLE accepts a new request on the next edge (the core drops req_valid after done).
- Bus-field stability: changes to address/data inputs while busy are ignored (registered copy is used).
- Reset asserted mid-REQ: mem_req drops immediately, and the transaction is abandoned with no done pulse.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8-bit+ counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT, the controller goes to ERR: done=1, flagError=1, mem_req dropped, Memoria unchanged.
- Undefined: no counter is built; REQ waits indefinitely for mem_ack.

Test Plan:
- LW, address=0x100, ack same cycle with rdata=0xDEADBEEF → mem_addr=0x100, be=4'hF; done 2 cycles after accept; Memoria=0xDEADBEEF; flagError=0.
- LB then LBU, address=0x103, rdata=0x80AABBCC, ack after 3 wait cycles → done in the ack cycle +1; Memoria=0xFFFFFF80 for LB, then 0x00000080 for LBU.
- SH, address=0x202, data_out=0x1234ABCD → mem_we=1, mem_addr=0x200, be=4'b1100, wdata=0xABCDABCD; Memoria unchanged.
- LW, address=0x101 → no mem_req; done=1 and flagError=1 one cycle after accept; busy for 1 cycle. Also SB with funct3=3 → same error response.
- Reset pulse (rst=0) mid-REQ after SW, address=0x10 → mem_req=0 and busy=0 immediately; no done pulse; next request works normally.
- LSU_TIMEOUT_EN defined, TIMEOUT=4, mem_ack held 0 → ERR after 4 REQ cycles: done=1, flagError=1, mem_req=0. Undefined: mem_req stays high for more than 100 cycles.
